// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial line in, received byte and status pulses out
interface uart_receiver_if;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;

    modport master (
        output rxd,
        input  data,
        input  valid,
        input  frame_err,
        input  parity_err
    );

    modport slave (
        input  rxd,
        output data,
        output valid,
        output frame_err,
        output parity_err
    );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver, mid-bit sampling; UART_RX_PARITY_EN adds an even-parity bit
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 2604
) (
    input  logic           CLK,
    input  logic           reset,
    uart_receiver_if.slave rx
);

    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;
`endif

    state_t      state_q;
    logic [1:0]  sync_q;
    logic        rxs;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic        parity_ok_q;
    logic        parity_err_q;
`endif

    // Flops preset to 1 so reset looks like an idle line, not a start bit.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx.rxd};
        end
    end

    assign rxs     = sync_q[1];
    assign shift_d = {rxs, shift_q[7:1]};

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_ok_q  <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_q <= S_START;
                        cnt_q   <= HALF_M1;
                    end
                end

                S_START: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (rxs) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q   <= S_DATA;
                        cnt_q     <= FULL_M1;
                        bit_idx_q <= 3'd0;
                    end
                end

                S_DATA: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        shift_q   <= shift_d;
                        cnt_q     <= FULL_M1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        parity_ok_q <= (rxs == ^shift_q);
                        cnt_q       <= FULL_M1;
                        state_q     <= S_STOP;
                    end
                end
`endif

                // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start.
                S_STOP: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (!rxs) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (!parity_ok_q) begin
                        parity_err_q <= 1'b1;
                        state_q      <= S_IDLE;
`endif
                    end else begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                S_BREAK: begin
                    if (rxs) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx.data      = data_q;
    assign rx.valid     = valid_q;
    assign rx.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = parity_err_q;
`else
    assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver at 16 clocks per bit
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int N = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME = (10 + PBITS) * N;
    localparam int LAT   = 154 + PBITS * N;

    localparam int K_VALID  = 0;
    localparam int K_FRAME  = 1;
    localparam int K_PARITY = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         fall;
    } exp_t;

    logic CLK = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic [7:0] model_data;

    uart_receiver_if tif ();

    uart_receiver #(.CLKS_PER_BIT(N)) dut (
        .CLK   (CLK),
        .reset (reset),
        .rx    (tif.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic drive_bit(input logic v, input int n);
        tif.rxd = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_wrong);
        exp_t e;
        e.fall = cyc;
        if (!stop) begin
            e.kind = K_FRAME;
            e.data = model_data;
        end else if (par_wrong && PBITS != 0) begin
            e.kind = K_PARITY;
            e.data = model_data;
        end else begin
            e.kind = K_VALID;
            e.data = b;
            model_data = b;
        end
        sb.push_back(e);
        drive_bit(1'b0, N);
        for (int i = 0; i < 8; i++) drive_bit(b[i], N);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_wrong, N);
`endif
        drive_bit(stop, N);
    endtask

    task automatic watch(input int n);
        exp_t e;
        int   got;
        repeat (n) begin
            @(negedge CLK);
            if (tif.valid || tif.frame_err || tif.parity_err) begin
                checks++;
                if ($countones({tif.valid, tif.frame_err, tif.parity_err}) != 1) begin
                    errors++;
                    $display("FAIL exclusive_pulses: got %b expected one-hot", {tif.valid, tif.frame_err, tif.parity_err});
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got pulse %b at cycle %0d expected none", {tif.valid, tif.frame_err, tif.parity_err}, cyc);
                end else begin
                    e   = sb.pop_front();
                    got = tif.valid ? K_VALID : (tif.frame_err ? K_FRAME : K_PARITY);
                    checks++;
                    if (got !== e.kind) begin
                        errors++;
                        $display("FAIL pulse_kind: got %0d expected %0d", got, e.kind);
                    end
                    checks++;
                    if (tif.data !== e.data) begin
                        errors++;
                        $display("FAIL pulse_data: got %02h expected %02h", tif.data, e.data);
                    end
                    checks++;
                    if ((cyc - e.fall) < LAT - 2 || (cyc - e.fall) > LAT + 2) begin
                        errors++;
                        $display("FAIL pulse_latency: got %0d expected %0d +/-2", cyc - e.fall, LAT);
                    end
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_pulses: got %0d outstanding expected 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({tif.data, tif.valid, tif.frame_err, tif.parity_err} !== 11'd0) begin
            errors++;
            $display("FAIL %s: got data=%02h v=%b fe=%b pe=%b expected all 0", name, tif.data, tif.valid, tif.frame_err, tif.parity_err);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        tif.rxd = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_outputs_zero("reset_outputs");
        reset      = 1'b1;
        model_data = 8'h00;
        drive_bit(1'b1, 2 * N);
        checks++;
        if (tif.data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_after_release: got %02h expected 00", tif.data);
        end
    endtask

    task automatic test_single();
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            watch(FRAME + 40);
        join
        check_empty("single");
    endtask

    task automatic test_glitch();
        fork
            begin
                drive_bit(1'b0, 5);
                drive_bit(1'b1, 60);
            end
            watch(80);
        join
        checks++;
        if (tif.data !== model_data) begin
            errors++;
            $display("FAIL glitch_data: got %02h expected %02h", tif.data, model_data);
        end
        check_empty("glitch");
    endtask

    task automatic test_frame_err();
        fork
            begin
                send_frame(8'h3C, 1'b0, 1'b0);
                drive_bit(1'b0, 100);
                drive_bit(1'b1, 3 * N);
                send_frame(8'h81, 1'b1, 1'b0);
            end
            watch(2 * FRAME + 100 + 3 * N + 40);
        join
        check_empty("frame_err");
    endtask

    task automatic test_back_to_back();
        fork
            begin
                send_frame(8'h00, 1'b1, 1'b0);
                send_frame(8'hFF, 1'b1, 1'b0);
                send_frame(8'h55, 1'b1, 1'b0);
            end
            watch(3 * FRAME + 40);
        join
        check_empty("back_to_back");
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        fork
            begin
                send_frame(8'h07, 1'b1, 1'b1);
                drive_bit(1'b1, N);
                send_frame(8'h07, 1'b1, 1'b0);
            end
            watch(2 * FRAME + N + 40);
        join
        check_empty("parity");
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [7:0] partial;
        partial = 8'hC3;
        fork
            begin
                drive_bit(1'b0, N);
                for (int i = 0; i < 4; i++) drive_bit(partial[i], N);
                drive_bit(partial[4], N / 2);
                reset   = 1'b0;
                tif.rxd = 1'b1;
                repeat (3) @(posedge CLK);
                #1;
                check_outputs_zero("mid_frame_reset_outputs");
                model_data = 8'h00;
                repeat (10) @(posedge CLK);
                #1;
                reset = 1'b1;
                drive_bit(1'b1, 3 * N);
                send_frame(8'h5A, 1'b1, 1'b0);
            end
            watch(3 * FRAME);
        join
        check_empty("reset_mid_frame");
    endtask

    task automatic test_random();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send_frame(8'($urandom), 1'b1, 1'b0);
                    drive_bit(1'b1, $urandom_range(1, 20));
                end
            end
            watch(4 * (FRAME + 20) + 40);
        join
        check_empty("random");
    endtask

    initial begin
        reset      = 1'b0;
        tif.rxd    = 1'b1;
        model_data = 8'h00;
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
